// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared cpu types for the fetch front end: virtual address type, boot vector default,
// sequencer state encoding and the aligned sequential-PC helper.
package fetch_pc_sequencer_pkg;

    localparam int unsigned VADDR_W = 32;

    typedef logic [VADDR_W-1:0] virt_t;

    localparam virt_t DEFAULT_BOOT_VEC = 32'hbfc0_0000;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_DSLOT  = 1'b1
    } seq_state_e;

    // Start of the next aligned fetch group, 32-bit modulo.
    function automatic virt_t seq_pc(input virt_t pc, input int unsigned align);
        virt_t grp;
        grp = virt_t'(1) << align;
        return (pc & ~(grp - virt_t'(1))) + grp;
    endfunction

endpackage

// File: rtl/fetch_pc_sequencer_redirect_arbiter.sv
// Fixed-priority redirect arbiter: lowest index wins, one-hot grant plus target mux.
module redirect_arbiter
    import fetch_pc_sequencer_pkg::*;
#(
    parameter int unsigned NUM_REDIRECT = 4
) (
    input  logic                     [NUM_REDIRECT-1:0] req_i,
    input  virt_t [NUM_REDIRECT-1:0]                    vaddr_i,
    output logic                     [NUM_REDIRECT-1:0] grant_o,
    output logic                                        valid_o,
    output virt_t                                       vaddr_o
);

    // Isolate the lowest set request bit, then OR-mux the granted target.
    always_comb begin
        grant_o = req_i & (~req_i + NUM_REDIRECT'(1));
        valid_o = |req_i;
        vaddr_o = '0;
        for (int i = 0; i < int'(NUM_REDIRECT); i++) begin
            if (grant_o[i]) begin
                vaddr_o = vaddr_o | vaddr_i[i];
            end
        end
    end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch-group PC generator: sequential advance, same-cycle prediction with out-of-group
// delay slots, and prioritised redirects. Optional: FETCH_PC_ALIGN_CHECK_EN.
module fetch_pc_sequencer
    import fetch_pc_sequencer_pkg::*;
#(
    parameter int unsigned FETCH_WIDTH  = 2,
    parameter int unsigned NUM_REDIRECT = 4,
    parameter virt_t       BOOT_VEC     = DEFAULT_BOOT_VEC,
    localparam int unsigned SLOT_W      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                ready,
    input  logic                                hold_pc,
    input  logic                                predict_valid,
    input  logic  [SLOT_W-1:0]                  predict_slot,
    input  virt_t                               predict_vaddr,
    input  logic  [NUM_REDIRECT-1:0]            redirect_valid,
    input  virt_t [NUM_REDIRECT-1:0]            redirect_vaddr,
    output virt_t                               pc,
    output logic                                pc_en,
    output logic                                delayslot_pending,
    output logic  [NUM_REDIRECT-1:0]            redirect_grant,
    output logic                                pc_misaligned
);

    localparam int unsigned ALIGN     = $clog2(FETCH_WIDTH) + 2;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FETCH_WIDTH - 1);

    virt_t       pc_q, pc_d;
    virt_t       tgt_q, tgt_d;
    seq_state_e  state_q, state_d;

    logic                    arb_valid;
    virt_t                   arb_vaddr;
    logic [NUM_REDIRECT-1:0] arb_grant;

    logic                    fire;
    logic                    load;
    logic                    pred_hit;
    logic [SLOT_W-1:0]       slot_off;
    virt_t                   seq;
    virt_t                   npc;
    virt_t                   load_val;

    redirect_arbiter #(
        .NUM_REDIRECT (NUM_REDIRECT)
    ) u_redirect_arbiter (
        .req_i   (redirect_valid),
        .vaddr_i (redirect_vaddr),
        .grant_o (arb_grant),
        .valid_o (arb_valid),
        .vaddr_o (arb_vaddr)
    );

    assign fire     = ready & ~hold_pc;
    assign seq      = seq_pc(pc_q, ALIGN);
    assign slot_off = SLOT_W'((pc_q >> 2) & virt_t'(FETCH_WIDTH - 1));
    // Branches in slots before the group entry point were never fetched.
    assign pred_hit = predict_valid & (predict_slot >= slot_off);

    // Next-PC selection in priority order: redirect, stall, delay-slot target, prediction, seq.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        npc     = pc_q;
        load    = 1'b0;
        if (arb_valid) begin
            npc     = arb_vaddr;
            load    = 1'b1;
            state_d = ST_NORMAL;
        end else if (fire) begin
            load = 1'b1;
            if (state_q == ST_DSLOT) begin
                npc     = tgt_q;
                state_d = ST_NORMAL;
            end else if (pred_hit && (predict_slot < LAST_SLOT)) begin
                npc = predict_vaddr;
            end else if (pred_hit && (predict_slot == LAST_SLOT)) begin
                npc     = seq;
                tgt_d   = predict_vaddr;
                state_d = ST_DSLOT;
            end else begin
                npc = seq;
            end
        end
    end

`ifdef FETCH_PC_ALIGN_CHECK_EN
    logic mis_q, mis_d;

    assign load_val = npc;
    assign mis_d    = load ? (npc[1:0] != 2'b00) : mis_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign pc_misaligned = mis_q;
`else
    // Word alignment is enforced on every load instead of being reported.
    assign load_val      = npc & ~virt_t'(3);
    assign pc_misaligned = 1'b0;
`endif

    assign pc_d = load ? load_val : pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= BOOT_VEC;
            tgt_q   <= '0;
            state_q <= ST_NORMAL;
        end else begin
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            state_q <= state_d;
        end
    end

    assign pc                = pc_q;
    assign pc_en             = fire;
    assign delayslot_pending = (state_q == ST_DSLOT);
    assign redirect_grant    = rst ? '0 : arb_grant;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Self-checking bench for fetch_pc_sequencer: directed scenarios then randomized traffic
// against a behavioural model of the next-PC rules.
module tb_fetch_pc_sequencer;

    localparam int FW = 2;
    localparam int NR = 4;
    localparam logic [31:0] BOOT = 32'hbfc0_0000;

    logic              clk;
    logic              rst;
    logic              ready;
    logic              hold_pc;
    logic              predict_valid;
    logic [0:0]        predict_slot;
    logic [31:0]       predict_vaddr;
    logic [NR-1:0]     redirect_valid;
    logic [NR-1:0][31:0] redirect_vaddr;
    logic [31:0]       pc;
    logic              pc_en;
    logic              delayslot_pending;
    logic [NR-1:0]     redirect_grant;
    logic              pc_misaligned;

    int checks;
    int failures;

    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    bit          m_pend;
    bit          m_mis;

    fetch_pc_sequencer #(
        .FETCH_WIDTH  (FW),
        .NUM_REDIRECT (NR),
        .BOOT_VEC     (BOOT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ready             (ready),
        .hold_pc           (hold_pc),
        .predict_valid     (predict_valid),
        .predict_slot      (predict_slot),
        .predict_vaddr     (predict_vaddr),
        .redirect_valid    (redirect_valid),
        .redirect_vaddr    (redirect_vaddr),
        .pc                (pc),
        .pc_en             (pc_en),
        .delayslot_pending (delayslot_pending),
        .redirect_grant    (redirect_grant),
        .pc_misaligned     (pc_misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic step();
        logic [NR-1:0] eg;
        logic [31:0]   n_pc, n_tgt, grp_base, seq;
        bit            n_pend, n_mis, fire, load;
        int            sel, off;
        #1;
        sel = -1;
        for (int i = 0; i < NR; i++) begin
            if (redirect_valid[i] && sel < 0) sel = i;
        end
        eg = '0;
        if (!rst && sel >= 0) eg[sel] = 1'b1;
        fire = ready && !hold_pc;
        check_eq("grant", 32'(redirect_grant), 32'(eg));
        check_eq("pc_en", 32'(pc_en), 32'(fire));

        grp_base = m_pc / (4 * FW) * (4 * FW);
        seq      = grp_base + 32'(4 * FW);
        off      = int'((m_pc / 4) % FW);
        n_pc = m_pc; n_tgt = m_tgt; n_pend = m_pend; n_mis = m_mis; load = 1'b0;
        if (rst) begin
            n_pc = BOOT; n_tgt = '0; n_pend = 0; n_mis = 0;
        end else begin
            if (sel >= 0) begin
                n_pc = redirect_vaddr[sel]; n_pend = 0; load = 1;
            end else if (!fire) begin
                load = 0;
            end else if (m_pend) begin
                n_pc = m_tgt; n_pend = 0; load = 1;
            end else if (predict_valid && int'(predict_slot) >= off && int'(predict_slot) < FW - 1) begin
                n_pc = predict_vaddr; load = 1;
            end else if (predict_valid && int'(predict_slot) >= off && int'(predict_slot) == FW - 1) begin
                n_pc = seq; n_tgt = predict_vaddr; n_pend = 1; load = 1;
            end else begin
                n_pc = seq; load = 1;
            end
            if (load) begin
`ifdef FETCH_PC_ALIGN_CHECK_EN
                n_mis = (n_pc % 4) != 0;
`else
                n_pc  = n_pc - (n_pc % 4);
                n_mis = 0;
`endif
            end
        end

        @(posedge clk);
        #1;
        m_pc = n_pc; m_tgt = n_tgt; m_pend = n_pend; m_mis = n_mis;
        check_eq("pc", pc, m_pc);
        check_eq("dslot_pending", 32'(delayslot_pending), 32'(m_pend));
        check_eq("misaligned", 32'(pc_misaligned), 32'(m_mis));
    endtask

    task automatic redirect_to(input int ch, input logic [31:0] addr);
        ready          = 1'b0;
        redirect_valid = '0;
        redirect_valid[ch] = 1'b1;
        redirect_vaddr[ch] = addr;
        step();
        redirect_valid = '0;
    endtask

    initial begin
        checks = 0; failures = 0;
        m_pc = '0; m_tgt = '0; m_pend = 0; m_mis = 0;
        rst = 1'b1; ready = 1'b0; hold_pc = 1'b0;
        predict_valid = 1'b0; predict_slot = '0; predict_vaddr = '0;
        redirect_valid = '0; redirect_vaddr = '0;

        // Reset and sequential advance
        step();
        check_eq("tp_reset_pc", pc, 32'hbfc0_0000);
        rst = 1'b0;
        ready = 1'b1;
        step(); check_eq("tp_seq1", pc, 32'hbfc0_0008);
        step(); check_eq("tp_seq2", pc, 32'hbfc0_0010);
        step(); check_eq("tp_seq3", pc, 32'hbfc0_0018);

        // Prediction with delay slot inside the group
        redirect_to(3, 32'hbfc0_0000);
        ready = 1'b1; predict_valid = 1'b1; predict_slot = 1'b0; predict_vaddr = 32'h8000_1000;
        step(); check_eq("tp_pred_same", pc, 32'h8000_1000);
        check_eq("tp_pred_same_pend", 32'(delayslot_pending), 32'd0);
        predict_valid = 1'b0;

        // Prediction in the last slot: delay slot fetched next, then target
        redirect_to(3, 32'hbfc0_0000);
        ready = 1'b1; predict_valid = 1'b1; predict_slot = 1'b1; predict_vaddr = 32'h8000_1000;
        step(); check_eq("tp_dslot_pc", pc, 32'hbfc0_0008);
        check_eq("tp_dslot_pend", 32'(delayslot_pending), 32'd1);
        predict_slot = 1'b0; predict_vaddr = 32'h1234_5678;
        step(); check_eq("tp_dslot_tgt", pc, 32'h8000_1000);
        check_eq("tp_dslot_done", 32'(delayslot_pending), 32'd0);
        predict_valid = 1'b0;

        // Redirect during DSLOT, two channels competing
        redirect_to(3, 32'hbfc0_0000);
        ready = 1'b1; predict_valid = 1'b1; predict_slot = 1'b1; predict_vaddr = 32'h8000_1000;
        step();
        predict_valid = 1'b0;
        redirect_valid = 4'b0101;
        redirect_vaddr[0] = 32'h8000_0180;
        redirect_vaddr[2] = 32'h8000_2000;
        #1;
        check_eq("tp_grant", 32'(redirect_grant), 32'h1);
        step(); check_eq("tp_redir_pc", pc, 32'h8000_0180);
        check_eq("tp_redir_pend", 32'(delayslot_pending), 32'd0);
        redirect_valid = '0;

        // Stall holds pc; redirect still lands during the stall
        redirect_to(1, 32'h8000_0040);
        ready = 1'b0;
        step(); check_eq("tp_stall_hold", pc, 32'h8000_0040);
        redirect_valid = 4'b0010; redirect_vaddr[1] = 32'h8000_0300;
        step(); check_eq("tp_stall_redir", pc, 32'h8000_0300);
        redirect_valid = '0;
        step(); check_eq("tp_stall_hold2", pc, 32'h8000_0300);

        // Address wrap
        redirect_to(0, 32'hffff_fff8);
        ready = 1'b1;
        step(); check_eq("tp_wrap", pc, 32'h0000_0000);

        // Misaligned redirect
        redirect_to(2, 32'h8000_0002);
`ifdef FETCH_PC_ALIGN_CHECK_EN
        check_eq("tp_mis_pc", pc, 32'h8000_0002);
        check_eq("tp_mis_flag", 32'(pc_misaligned), 32'd1);
`else
        check_eq("tp_mis_pc", pc, 32'h8000_0000);
        check_eq("tp_mis_flag", 32'(pc_misaligned), 32'd0);
`endif
        ready = 1'b1;
        step(); check_eq("tp_mis_seq", pc, 32'h8000_0008);

        // Reset discards a pending delay-slot target
        redirect_to(0, 32'hbfc0_0000);
        ready = 1'b1; predict_valid = 1'b1; predict_slot = 1'b1; predict_vaddr = 32'h8000_5000;
        step();
        predict_valid = 1'b0; rst = 1'b1;
        step(); check_eq("tp_rst_dslot", 32'(delayslot_pending), 32'd0);
        rst = 1'b0;
        step(); check_eq("tp_rst_seq", pc, 32'hbfc0_0008);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 199) == 0);
            ready         = ($urandom_range(0, 3) != 0);
            hold_pc       = ($urandom_range(0, 9) == 0);
            predict_valid = ($urandom_range(0, 9) < 4);
            predict_slot  = 1'($urandom_range(0, 1));
            predict_vaddr = $urandom & (($urandom_range(0, 7) == 0) ? 32'hffff_ffff : 32'hffff_fffc);
            for (int i = 0; i < NR; i++) begin
                redirect_valid[i] = ($urandom_range(0, 19) == 0);
                redirect_vaddr[i] = $urandom & (($urandom_range(0, 7) == 0) ? 32'hffff_ffff : 32'hffff_fffc);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_pc_sequencer.md
# fetch_pc_sequencer

Parametrised fetch-address generator at the head of the fetch pipeline. It holds the current fetch-group PC and advances it by one aligned fetch group per accepted fetch. It follows same-cycle branch predictions, including MIPS delay slots that fall outside the current group. It arbitrates an arbitrary number of prioritised redirect channels (exception, resolved/presolved mispredict, replay) into a single registered PC.

## Interface
Parameters:
- FETCH_WIDTH, 2, instructions per fetch group; power of two, 1..8
- NUM_REDIRECT, 4, redirect channels; index 0 = highest priority
- BOOT_VEC, 32'hbfc0_0000, reset PC

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ready  in  1  fetch stage accepts current PC this cycle
- hold_pc  in  1  suppress advance even if ready
- predict_valid  in  1  BTB/BHT predicts a taken branch in the current group (combinational, same cycle as pc)
- predict_slot  in  $clog2(FETCH_WIDTH) (min 1)  slot index of the predicted branch within the group
- predict_vaddr  in  32  predicted target
- redirect_valid  in  NUM_REDIRECT  redirect requests
- redirect_vaddr  in  NUM_REDIRECT×32  redirect targets
- pc  out  32  current fetch-group PC (registered)
- pc_en  out  1  = ready & ~hold_pc (fire)
- delayslot_pending  out  1  current group is a delay-slot-only fetch; target already queued
- redirect_grant  out  NUM_REDIRECT  one-hot, the channel applied this cycle
- pc_misaligned  out  1  see Configuration

## Operation
- ALIGN = $clog2(FETCH_WIDTH)+2. seq = {pc[31:ALIGN]+1, ALIGN'b0}, 32-bit modulo; 0xFFFF_FFF8 with FETCH_WIDTH=2 wraps to 0.
- Slot offset of pc = pc[ALIGN-1:2]. A prediction with predict_slot < offset is ignored.
- States: NORMAL, DSLOT. Saved target register tgt_q.
- Priority per cycle, highest first:
  - Redirect: if any redirect_valid, select the lowest index, regardless of fire. npc = its vaddr; state → NORMAL; grant asserted for that index.
  - Otherwise, if not fire: pc and state hold.
  - Otherwise, in DSLOT: npc = tgt_q, state → NORMAL; predict ignored.
  - Otherwise, in NORMAL with a valid prediction and predict_slot < FETCH_WIDTH-1: the delay slot is in the same group, so npc = predict_vaddr.
  - Otherwise, in NORMAL with a valid prediction and predict_slot = FETCH_WIDTH-1: npc = seq, tgt_q ← predict_vaddr, state → DSLOT.
  - Otherwise: npc = seq.
- With FETCH_WIDTH=1, every predicted branch takes the DSLOT path.
- delayslot_pending = (state == DSLOT).
- Reset values: pc = BOOT_VEC, state NORMAL, tgt_q = 0, delayslot_pending 0, redirect_grant 0, pc_misaligned 0.

## Timing
- pc is registered. Fire, redirect or prediction in cycle N gives the new pc in cycle N+1. Predict→pc latency is 1 cycle, zero bubbles.
- Redirect→pc latency is 1 cycle even when ready=0. A redirect is never dropped, and it cancels any pending DSLOT target.
- Simultaneous redirects: only the lowest index is granted; the others are the requester's responsibility to drop or re-assert.
- rst at any cycle: everything returns to reset values next cycle, and a pending DSLOT target is discarded.
- ready low holds pc. Unlike the previous generator, a stall does not reload BOOT_VEC.

## Configuration
- FETCH_PC_ALIGN_CHECK_EN defined: pc_misaligned is registered and equals (npc[1:0] != 0) for the value loaded into pc. The fetch stage raises AdEL, and the sequencer still advances normally by seq.
- Undefined: pc_misaligned is tied 0 and pc[1:0] is forced to 0 on every load.

## Structure
- Shared cpu package: virt_t, and the BOOT_VEC default constant.
- Sub-module redirect_arbiter (parametrised NUM_REDIRECT): fixed-priority one-hot grant plus mux.
- fetch_pc_sequencer instantiates redirect_arbiter and holds the pc, state and tgt_q registers.

## Test plan
- Reset, then ready=1 for 3 cycles (FETCH_WIDTH=2) → pc 0xbfc00000, 0xbfc00008, 0xbfc00010, 0xbfc00018.
- pc 0xbfc00000, predict slot 0, target 0x80001000 → next pc 0x80001000, delayslot_pending 0.
- pc 0xbfc00000, predict slot 1, target 0x80001000 → pc 0xbfc00008 with delayslot_pending 1, then 0x80001000 with pending 0.
- In DSLOT, redirect_valid=4'b0101, vaddr[0]=0x80000180, vaddr[2]=0x80002000 → pc 0x80000180, grant 4'b0001, pending 0.
- ready=0 for 3 cycles at 0x80000040 → pc holds; a redirect to 0x80000300 on the 2nd stall cycle → pc 0x80000300 next cycle.
- Wrap and misalignment:
  - pc 0xfffffff8, fire → pc 0x00000000.
  - With FETCH_PC_ALIGN_CHECK_EN, redirect to 0x80000002 → pc_misaligned 1.
  - Without the macro, the same redirect gives pc 0x80000000.
